// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between two
// requesters, with a tag pipeline routing read data back to its issuer.
module ram_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 10,
    parameter int RD_LAT     = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  A_REQ,
    input  logic                  A_WE,
    input  logic [ADDR_WIDTH-1:0] A_ADDR,
    input  logic [DATA_WIDTH-1:0] A_DIN,
    output logic                  A_GNT,
    output logic                  A_RVALID,
    output logic [DATA_WIDTH-1:0] A_RDATA,
    input  logic                  B_REQ,
    input  logic                  B_WE,
    input  logic [ADDR_WIDTH-1:0] B_ADDR,
    input  logic [DATA_WIDTH-1:0] B_DIN,
    output logic                  B_GNT,
    output logic                  B_RVALID,
    output logic [DATA_WIDTH-1:0] B_RDATA,
    output logic                  RAM_EN,
    output logic                  RAM_WE,
    output logic [ADDR_WIDTH-1:0] RAM_ADDR,
    output logic [DATA_WIDTH-1:0] RAM_DIN,
    input  logic [DATA_WIDTH-1:0] RAM_DOUT
);

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;
    localparam int   DEPTH  = RD_LAT + 1;

    logic                  last_q, last_d;
    logic                  ram_en_q, ram_en_d;
    logic                  ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_din_q, ram_din_d;
    logic [DEPTH-1:0]      tag_vld_q, tag_vld_d;
    logic [DEPTH-1:0]      tag_port_q, tag_port_d;
    logic                  a_rvalid_q, a_rvalid_d;
    logic                  b_rvalid_q, b_rvalid_d;
    logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_WIDTH-1:0] b_rdata_q, b_rdata_d;

    logic                  a_gnt, b_gnt, gnt;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_din;
    logic                  tag_out_vld, tag_out_port;

    // Pick at most one requester; on contention the port not served last wins.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (!RST) begin
            if (A_REQ && (!B_REQ || last_q == PORT_B)) begin
                a_gnt = 1'b1;
            end else if (B_REQ) begin
                b_gnt = 1'b1;
            end
        end
    end

    // Build the next RAM command, priority pointer, tag shift and read return.
    always_comb begin
        gnt      = a_gnt | b_gnt;
        sel_we   = a_gnt ? A_WE   : B_WE;
        sel_addr = a_gnt ? A_ADDR : B_ADDR;
        sel_din  = a_gnt ? A_DIN  : B_DIN;

        ram_en_d   = gnt;
        ram_we_d   = gnt & sel_we;
        ram_addr_d = gnt ? sel_addr : ram_addr_q;
        ram_din_d  = gnt ? sel_din  : ram_din_q;
        last_d     = gnt ? b_gnt    : last_q;

        tag_vld_d  = {tag_vld_q[DEPTH-2:0], gnt & ~sel_we};
        tag_port_d = {tag_port_q[DEPTH-2:0], b_gnt};

        tag_out_vld  = tag_vld_q[DEPTH-1];
        tag_out_port = tag_port_q[DEPTH-1];

        a_rvalid_d = tag_out_vld & (tag_out_port == PORT_A);
        b_rvalid_d = tag_out_vld & (tag_out_port == PORT_B);
        a_rdata_d  = a_rvalid_d ? RAM_DOUT : a_rdata_q;
        b_rdata_d  = b_rvalid_d ? RAM_DOUT : b_rdata_q;
    end

    // State registers; reset drops in-flight tags so their data is never returned.
    always_ff @(posedge CLK) begin
        if (RST) begin
            last_q     <= PORT_B;
            ram_en_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            tag_vld_q  <= '0;
            tag_port_q <= '0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            last_q     <= last_d;
            ram_en_q   <= ram_en_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            tag_vld_q  <= tag_vld_d;
            tag_port_q <= tag_port_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

    assign A_GNT    = a_gnt;
    assign B_GNT    = b_gnt;
    assign A_RVALID = a_rvalid_q;
    assign B_RVALID = b_rvalid_q;
    assign A_RDATA  = a_rdata_q;
    assign B_RDATA  = b_rdata_q;
    assign RAM_EN   = ram_en_q;
    assign RAM_WE   = ram_we_q;
    assign RAM_ADDR = ram_addr_q;
    assign RAM_DIN  = ram_din_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural single-port RAM
// (read latency 1) and a monitor recording grants and read returns.
module tb_ram_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        A_REQ = 1'b0, A_WE = 1'b0;
    logic [7:0]  A_ADDR = '0;
    logic [9:0]  A_DIN = '0;
    logic        B_REQ = 1'b0, B_WE = 1'b0;
    logic [7:0]  B_ADDR = '0;
    logic [9:0]  B_DIN = '0;
    logic        A_GNT, A_RVALID, B_GNT, B_RVALID;
    logic [9:0]  A_RDATA, B_RDATA;
    logic        RAM_EN, RAM_WE;
    logic [7:0]  RAM_ADDR;
    logic [9:0]  RAM_DIN;
    logic [9:0]  ram_dout = '0;

    logic [9:0]  mem [0:255];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    logic [10:0] ret_q [$];
    int          ret_cyc [$];
    logic        gnt_port [$];
    int          gnt_cyc [$];

    always #5 CLK = ~CLK;

    ram_arbiter #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(10),
        .RD_LAT(1)
    ) dut (
        .CLK(CLK), .RST(RST),
        .A_REQ(A_REQ), .A_WE(A_WE), .A_ADDR(A_ADDR), .A_DIN(A_DIN),
        .A_GNT(A_GNT), .A_RVALID(A_RVALID), .A_RDATA(A_RDATA),
        .B_REQ(B_REQ), .B_WE(B_WE), .B_ADDR(B_ADDR), .B_DIN(B_DIN),
        .B_GNT(B_GNT), .B_RVALID(B_RVALID), .B_RDATA(B_RDATA),
        .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_ADDR(RAM_ADDR),
        .RAM_DIN(RAM_DIN), .RAM_DOUT(ram_dout)
    );

    // RAM: write or read at the edge where EN is seen, read data next cycle
    always @(posedge CLK) begin
        if (RAM_EN) begin
            if (RAM_WE) mem[RAM_ADDR] <= RAM_DIN;
            else        ram_dout <= mem[RAM_ADDR];
        end
    end

    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor sampled mid-cycle
    always @(negedge CLK) begin
        if (A_GNT) begin gnt_port.push_back(1'b0); gnt_cyc.push_back(cyc); end
        if (B_GNT) begin gnt_port.push_back(1'b1); gnt_cyc.push_back(cyc); end
        if (A_RVALID) begin ret_q.push_back({1'b0, A_RDATA}); ret_cyc.push_back(cyc); end
        if (B_RVALID) begin ret_q.push_back({1'b1, B_RDATA}); ret_cyc.push_back(cyc); end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic clr;
        ret_q.delete();
        ret_cyc.delete();
        gnt_port.delete();
        gnt_cyc.delete();
    endtask

    int        na, nb;
    logic [5:0] seq;

    initial begin
        // Reset with both requesting: no grants, all outputs zero
        A_REQ = 1'b1;
        B_REQ = 1'b1;
        tick;
        tick;
        #1;
        check("rst_gnt", 32'({A_GNT, B_GNT}), 32'd0);
        check("rst_cmd", 32'({RAM_EN, RAM_WE, RAM_ADDR, RAM_DIN}), 32'd0);
        check("rst_rd", 32'({A_RVALID, B_RVALID, A_RDATA, B_RDATA}), 32'd0);
        A_REQ = 1'b0;
        B_REQ = 1'b0;
        RST = 1'b0;
        tick;
        clr();

        // Single write from A
        A_REQ = 1'b1; A_WE = 1'b1; A_ADDR = 8'h05; A_DIN = 10'h2AA;
        #1;
        check("t1_gnt", 32'({A_GNT, B_GNT}), 32'b10);
        tick;
        A_REQ = 1'b0;
        #1;
        check("t1_cmd", 32'({RAM_EN, RAM_WE, RAM_ADDR, RAM_DIN}),
              32'({1'b1, 1'b1, 8'h05, 10'h2AA}));

        // Preload 30..35 and 10..13 with back-to-back writes
        for (int i = 0; i < 6; i++) begin
            A_REQ = 1'b1; A_WE = 1'b1;
            A_ADDR = 8'h30 + 8'(i); A_DIN = 10'h100 + 10'(i);
            tick;
        end
        for (int i = 0; i < 4; i++) begin
            A_REQ = 1'b1; A_WE = 1'b1;
            A_ADDR = 8'h10 + 8'(i); A_DIN = 10'h040 + 10'(i);
            tick;
        end
        A_REQ = 1'b0;
        tick;
        tick;
        check("idle_cmd", 32'({RAM_EN, RAM_WE, RAM_ADDR, RAM_DIN}),
              32'({1'b0, 1'b0, 8'h13, 10'h043}));
        tick;
        check("wr_no_rv", 32'(ret_q.size()), 32'd0);
        check("wr_gnts", 32'(gnt_port.size()), 32'd11);

        // Single read from A returns three cycles after grant
        clr();
        A_REQ = 1'b1; A_WE = 1'b0; A_ADDR = 8'h05;
        #1;
        check("t2_gnt", 32'({A_GNT, B_GNT}), 32'b10);
        tick;
        A_REQ = 1'b0;
        repeat (5) tick;
        check("t2_n", 32'(ret_q.size()), 32'd1);
        if (ret_q.size() >= 1 && gnt_cyc.size() >= 1) begin
            check("t2_data", 32'(ret_q[0]), 32'({1'b0, 10'h2AA}));
            check("t2_lat", 32'(ret_cyc[0] - gnt_cyc[0]), 32'd3);
        end

        // B alone: four back-to-back reads (leaves LAST = B)
        clr();
        for (int i = 0; i < 4; i++) begin
            B_REQ = 1'b1; B_WE = 1'b0; B_ADDR = 8'h10 + 8'(i);
            #1;
            check("t4_gnt", 32'(B_GNT), 32'd1);
            tick;
        end
        B_REQ = 1'b0;
        repeat (6) tick;
        check("t4_n", 32'(ret_q.size()), 32'd4);
        if (ret_q.size() == 4 && gnt_cyc.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("t4_data", 32'(ret_q[i]), 32'({1'b1, 10'h040 + 10'(i)}));
                check("t4_rcyc", 32'(ret_cyc[i] - ret_cyc[0]), 32'(i));
                check("t4_lat", 32'(ret_cyc[i] - gnt_cyc[i]), 32'd3);
            end
        end

        // Both requesting continuously: alternate A,B,A,B,A,B
        clr();
        na = 0;
        nb = 0;
        A_WE = 1'b0;
        B_WE = 1'b0;
        for (int k = 0; k < 12 && (na < 3 || nb < 3); k++) begin
            A_REQ = (na < 3);
            B_REQ = (nb < 3);
            A_ADDR = 8'h30 + 8'(2 * na);
            B_ADDR = 8'h31 + 8'(2 * nb);
            #1;
            if (A_GNT) na++;
            if (B_GNT) nb++;
            tick;
        end
        A_REQ = 1'b0;
        B_REQ = 1'b0;
        repeat (6) tick;
        seq = '0;
        foreach (gnt_port[i]) seq = {seq[4:0], gnt_port[i]};
        check("t3_ngnt", 32'(gnt_port.size()), 32'd6);
        check("t3_order", 32'(seq), 32'b010101);
        check("t3_n", 32'(ret_q.size()), 32'd6);
        if (ret_q.size() == 6 && gnt_cyc.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                check("t3_data", 32'(ret_q[i]),
                      32'({1'(i % 2), 10'h100 + 10'(i)}));
                check("t3_lat", 32'(ret_cyc[i] - gnt_cyc[i]), 32'd3);
            end
        end

        // Write from A then read from B on the next cycle
        clr();
        A_REQ = 1'b1; A_WE = 1'b1; A_ADDR = 8'h20; A_DIN = 10'h155;
        #1;
        tick;
        A_REQ = 1'b0;
        B_REQ = 1'b1; B_WE = 1'b0; B_ADDR = 8'h20;
        #1;
        check("t5_bgnt", 32'(B_GNT), 32'd1);
        tick;
        B_REQ = 1'b0;
        repeat (5) tick;
        check("t5_n", 32'(ret_q.size()), 32'd1);
        if (ret_q.size() >= 1)
            check("t5_data", 32'(ret_q[0]), 32'({1'b1, 10'h155}));

        // Two reads from A, then reset before either returns
        clr();
        A_REQ = 1'b1; A_WE = 1'b0; A_ADDR = 8'h05;
        #1;
        tick;
        A_ADDR = 8'h30;
        #1;
        tick;
        A_REQ = 1'b0;
        RST = 1'b1;
        tick;
        RST = 1'b0;
        #1;
        check("t6_cmd", 32'({RAM_EN, RAM_WE, RAM_ADDR, RAM_DIN}), 32'd0);
        check("t6_rd", 32'({A_RVALID, B_RVALID, A_RDATA, B_RDATA}), 32'd0);
        repeat (5) tick;
        check("t6_no_rv", 32'(ret_q.size()), 32'd0);
        A_REQ = 1'b1; A_WE = 1'b0; A_ADDR = 8'h05;
        B_REQ = 1'b1; B_WE = 1'b0; B_ADDR = 8'h10;
        #1;
        check("t6_first", 32'({A_GNT, B_GNT}), 32'b10);
        tick;
        A_REQ = 1'b0;
        B_REQ = 1'b0;
        repeat (3) tick;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-port round-robin arbiter that shares one single-port synchronous RAM (EN/WE/ADDR/Din/Dout interface) between requesters A and B.
- Each cycle it picks at most one request and drives a registered RAM command.
- It tracks in-flight reads with a tag pipeline and returns read data, with a valid strobe, to the requester that issued the read.
- It sits between the memory block and its two masters (e.g. CPU data port and DMA/loader).

Parameters:
- ADDR_WIDTH, 8, RAM address width
- DATA_WIDTH, 10, RAM data width
- RD_LAT, 1, RAM read latency in cycles: from the RAM sampling EN=1,WE=0 to RAM_DOUT valid (range 1..4)

Ports:
- CLK  in  1  single clock, rising edge
- RST  in  1  synchronous, active-high reset
- A_REQ  in  1  requester A wants a transaction
- A_WE  in  1  1 = write, 0 = read
- A_ADDR  in  ADDR_WIDTH  address
- A_DIN  in  DATA_WIDTH  write data
- A_GNT  out  1  combinational; request accepted this cycle
- A_RVALID  out  1  registered; A_RDATA valid this cycle
- A_RDATA  out  DATA_WIDTH  registered read data
- B_REQ, B_WE, B_ADDR, B_DIN, B_GNT, B_RVALID, B_RDATA: identical to the A signals, for requester B
- RAM_EN  out  1  registered RAM enable
- RAM_WE  out  1  registered RAM write enable
- RAM_ADDR  out  ADDR_WIDTH  registered RAM address
- RAM_DIN  out  DATA_WIDTH  registered RAM write data
- RAM_DOUT  in  DATA_WIDTH  RAM read data

Behaviour:
- Interface decision: one clock CLK; RST is synchronous and active-high.
- Reset values:
  - RAM_EN, RAM_WE, A_RVALID, B_RVALID = 0.
  - RAM_ADDR, RAM_DIN, A_RDATA, B_RDATA = 0.
  - Tag pipeline cleared.
  - Priority pointer LAST = B, so A wins the first contention.
- While RST=1, A_GNT = B_GNT = 0.
- Arbitration (combinational, cycle t):
  - Only A_REQ: A_GNT=1.
  - Only B_REQ: B_GNT=1.
  - Both: grant the port not equal to LAST.
  - Neither: no grant.
  - At most one GNT is high per cycle.
- Handshake:
  - A transaction is accepted at the rising edge ending a cycle with REQ=GNT=1.
  - The requester holds WE/ADDR/DIN stable while REQ=1 and GNT=0.
  - The requester may present a new request in cycle t+1 (back-to-back allowed).
  - REQ may drop without a grant; nothing is issued in that case.
- Command stage (edge end of t):
  - Granted transaction: RAM_EN=1, RAM_WE=granted WE, RAM_ADDR/RAM_DIN = granted values, LAST = granted port.
  - No grant: RAM_EN=0 and RAM_WE=0; ADDR/DIN hold their previous values. LAST is unchanged.
  - The command is visible to the RAM during cycle t+1.
- Round-robin:
  - LAST updates only on a grant.
  - A single continuous requester receives a grant every cycle.
  - Two continuous requesters alternate A,B,A,B.
- Read return:
  - A tag {valid, port} enters a shift pipeline of depth RD_LAT+1 with each issued read. Writes and idle cycles insert valid=0.
  - When the tag exits, at the edge ending cycle t+1+RD_LAT, the owning port's RDATA is loaded from RAM_DOUT and its RVALID is set for exactly that one cycle (t+2+RD_LAT). With RD_LAT=1 this is cycle t+3.
  - The other port's RVALID is 0 and its RDATA holds.
  - RDATA holds its value when RVALID=0.
- Ordering: read data is returned in issue order. Reads may be pipelined one per cycle; there is no limit on outstanding reads.
- Writes: no response strobe. Write completion is implied by GNT.
- Read-after-write to the same address from either port: the later-granted read returns the new data, because the RAM performs the write at an earlier edge.
- Reset mid-operation: in-flight read tags are discarded and no RVALID is produced for them. The RAM command is cleared in the cycle after the RST edge.
- Pipeline: no stalls. The arbiter never back-pressures read returns.
- Implementation scope: no combinational path from RAM_DOUT to any output. Target approximately 150-250 lines of RTL.

Test Plan:
- Reset, then A_REQ=1, A_WE=1, A_ADDR=8'h05, A_DIN=10'h2AA for one cycle -> A_GNT=1 in the same cycle. Next cycle RAM_EN=1, RAM_WE=1, RAM_ADDR=8'h05, RAM_DIN=10'h2AA. No A_RVALID is produced.
- A read of 8'h05 granted in cycle t (RD_LAT=1) -> A_RVALID=1 only in cycle t+3 with A_RDATA=10'h2AA. B_RVALID stays 0 throughout.
- A_REQ and B_REQ held high for 6 cycles, all reads to distinct pre-written addresses -> grant sequence A,B,A,B,A,B. RVALIDs return in the same order, each with the correct data, 3 cycles after the corresponding grant.
- B alone issues 4 back-to-back reads of 8'h10..8'h13 -> B_GNT=1 on 4 consecutive cycles. B_RVALID=1 on 4 consecutive cycles, data in address order.
- A writes 10'h155 to 8'h20 in cycle t; B reads 8'h20 in cycle t+1 -> B_RDATA=10'h155.
- Issue 2 reads, assert RST for 1 cycle before their data returns -> no RVALID for either read. All outputs at reset values after the reset edge. A wins the first contention after reset.
